// File: rtl/fifo_pkg.sv
// Shared constants and pointer arithmetic for the synchronous FIFO controllers.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 5;

    // Wrap-aware occupancy: (wr - rd) modulo 2**ptr_w, pointers carry the wrap bit.
    function automatic logic [31:0] ptr_count(input logic [31:0] wr,
                                              input logic [31:0] rd,
                                              input int          ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr_status.sv
// Combinational FIFO status from a read/write pointer pair; shared by both controllers.
module fifo_ptr_status
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AE_THRESH = 2
) (
    input  logic [ADDR_W:0] rd_ptr,
    input  logic [ADDR_W:0] wr_ptr,
    output logic            empty,
    output logic            almost_empty,
    output logic            over_depth,
    output logic [ADDR_W:0] count
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_V = PTR_W'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] AE_V    = PTR_W'(AE_THRESH);

    assign count        = PTR_W'(ptr_count(32'(wr_ptr), 32'(rd_ptr), PTR_W));
    assign empty        = (rd_ptr == wr_ptr);
    assign almost_empty = (count <= AE_V);
    // Only reachable if the pointers have been corrupted; legal maximum is DEPTH.
    assign over_depth   = (count > DEPTH_V);

endmodule

// File: rtl/fifo_read_ctrl_p.sv
// Read-side FIFO controller: owns rd_ptr, pops into a registered output, flags underflow/corruption.
module fifo_read_ctrl_p
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    input  logic              underflow_clr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [DATA_W-1:0] data_out_f,
    output logic              data_valid,
    output logic              read_en_o,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              underflow,
    output logic              ptr_err
);

    logic [ADDR_W:0]   rd_ptr_q;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              underflow_q;
    logic              ptr_err_q;
    logic              over_depth;
    logic              pop;

    fifo_ptr_status #(
        .ADDR_W    (ADDR_W),
        .AE_THRESH (AE_THRESH)
    ) u_status (
        .rd_ptr       (rd_ptr_q),
        .wr_ptr       (wr_ptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .over_depth   (over_depth),
        .count        (count)
    );

    assign pop = read_en && !empty && !flush;

    // Stage p1: popped word and its valid, one cycle after the accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            data_p1     <= '0;
            vld_p1      <= 1'b0;
            underflow_q <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (flush) begin
                rd_ptr_q <= wr_ptr;
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_p1  <= mem_rdata;
                vld_p1   <= 1'b1;
            end
            if (read_en && empty && !flush)
                underflow_q <= 1'b1;
            else if (underflow_clr)
                underflow_q <= 1'b0;
            if (over_depth)
                ptr_err_q <= 1'b1;
        end
    end

    assign rd_ptr     = rd_ptr_q;
    assign rd_addr    = rd_ptr_q[ADDR_W-1:0];
    assign data_out_f = data_p1;
    assign data_valid = vld_p1;
    assign read_en_o  = vld_p1;
    assign underflow  = underflow_q;
    assign ptr_err    = ptr_err_q;

endmodule

// File: tb/tb_fifo_read_ctrl_p.sv
// Self-checking bench for fifo_read_ctrl_p: status vector table, scoreboard for popped words.
module tb_fifo_read_ctrl_p;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              read_en;
    logic [ADDR_W:0]   wr_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              flush;
    logic              underflow_clr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr;
    logic [DATA_W-1:0] data_out_f;
    logic              data_valid;
    logic              read_en_o;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              underflow;
    logic              ptr_err;

    fifo_read_ctrl_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AE_THRESH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .read_en       (read_en),
        .wr_ptr        (wr_ptr),
        .mem_rdata     (mem_rdata),
        .flush         (flush),
        .underflow_clr (underflow_clr),
        .rd_addr       (rd_addr),
        .rd_ptr        (rd_ptr),
        .data_out_f    (data_out_f),
        .data_valid    (data_valid),
        .read_en_o     (read_en_o),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .count         (count),
        .underflow     (underflow),
        .ptr_err       (ptr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W:0]   m_rd;
    logic [DATA_W-1:0] m_data;
    logic              m_uf;
    logic              m_perr;
    logic [DATA_W-1:0] sb_q[$];

    typedef struct {
        logic [ADDR_W:0] wr;
        logic [ADDR_W:0] exp_count;
        logic            exp_empty;
        logic            exp_ae;
    } status_vec_t;

    status_vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_status(input string tag);
        logic [ADDR_W:0] c;
        #1;
        c = wr_ptr - m_rd;
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 2));
    endtask

    // Advance one clock: predict from the driven inputs, then check registered outputs.
    task automatic cycle(input string tag);
        logic [ADDR_W:0] c;
        logic            nv;
        logic [DATA_W-1:0] exp_d;
        c  = wr_ptr - m_rd;
        nv = 1'b0;
        if (reset) begin
            m_rd = '0; m_data = '0; m_uf = 1'b0; m_perr = 1'b0;
        end else begin
            if (flush) m_rd = wr_ptr;
            else if (read_en && c != 0) begin
                m_rd = m_rd + 1'b1;
                sb_q.push_back(mem_rdata);
                nv = 1'b1;
            end
            if (read_en && c == 0 && !flush) m_uf = 1'b1;
            else if (underflow_clr) m_uf = 1'b0;
            if (c > 32) m_perr = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(nv));
        chk({tag, ".read_en_o"}, 32'(read_en_o), 32'(nv));
        chk({tag, ".rd_ptr"}, 32'(rd_ptr), 32'(m_rd));
        chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(m_rd[ADDR_W-1:0]));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
        chk({tag, ".ptr_err"}, 32'(ptr_err), 32'(m_perr));
        if (nv) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".scoreboard_empty"}, 32'(1), 32'(0));
            end else begin
                exp_d = sb_q.pop_front();
                m_data = exp_d;
            end
        end
        chk({tag, ".data_out_f"}, 32'(data_out_f), 32'(m_data));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; read_en = 1'b0; flush = 1'b0; underflow_clr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{6'd0,  6'd0,  1'b1, 1'b1};
        vecs[1] = '{6'd1,  6'd1,  1'b0, 1'b1};
        vecs[2] = '{6'd2,  6'd2,  1'b0, 1'b1};
        vecs[3] = '{6'd3,  6'd3,  1'b0, 1'b0};
        vecs[4] = '{6'd17, 6'd17, 1'b0, 1'b0};
        vecs[5] = '{6'd31, 6'd31, 1'b0, 1'b0};
        vecs[6] = '{6'd32, 6'd32, 1'b0, 1'b0};

        m_rd = '0; m_data = '0; m_uf = 1'b0; m_perr = 1'b0;
        idle_inputs();
        reset = 1'b1; wr_ptr = '0; mem_rdata = 8'hA5;
        cycle("reset0");
        cycle("reset1");
        reset = 1'b0;
        chk_status("after_reset");

        // Read on empty sets underflow; a later clear pulse drops it.
        read_en = 1'b1;
        cycle("rd_empty");
        read_en = 1'b0; underflow_clr = 1'b1;
        cycle("uf_clr");
        underflow_clr = 1'b0;

        // Status table with rd_ptr = 0.
        for (int i = 0; i < 7; i++) begin
            wr_ptr = vecs[i].wr;
            #1;
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d.ae", i), 32'(almost_empty), 32'(vecs[i].exp_ae));
        end

        // Three back-to-back pops including a zero data word.
        wr_ptr = 6'd3; read_en = 1'b1;
        mem_rdata = 8'h00; cycle("pop0");
        mem_rdata = 8'h5A; cycle("pop1");
        mem_rdata = 8'hFF; cycle("pop2");
        read_en = 1'b0;
        cycle("pop_done");
        chk_status("drained");

        // Pointer wrap: rd 31 -> 33 across the wrap bit.
        wr_ptr = 6'd31; flush = 1'b1;
        cycle("flush_to_31");
        flush = 1'b0; wr_ptr = 6'd33;
        chk_status("wrap_status");
        read_en = 1'b1;
        mem_rdata = 8'h11; cycle("wrap_pop0");
        mem_rdata = 8'h22; cycle("wrap_pop1");
        read_en = 1'b0;
        chk_status("wrap_empty");

        // Flush beats a simultaneous read with five words stored.
        wr_ptr = 6'd38; read_en = 1'b1; flush = 1'b1; mem_rdata = 8'h77;
        cycle("flush_rd");
        read_en = 1'b0; flush = 1'b0;
        chk_status("flushed");

        // Set wins over clear on underflow.
        read_en = 1'b1; underflow_clr = 1'b1;
        cycle("uf_set_clr");
        idle_inputs();
        cycle("uf_hold");

        // Full and pointer corruption.
        reset = 1'b1; wr_ptr = '0;
        cycle("reset2");
        reset = 1'b0; wr_ptr = 6'd32;
        chk_status("full");
        cycle("full_idle");
        wr_ptr = 6'd40;
        cycle("corrupt");
        wr_ptr = 6'd0;
        cycle("corrupt_hold0");
        cycle("corrupt_hold1");
        reset = 1'b1;
        cycle("reset3");
        reset = 1'b0;

        // Reset mid-burst drops the pop in the reset cycle.
        wr_ptr = 6'd4; read_en = 1'b1; mem_rdata = 8'hC3;
        cycle("burst0");
        reset = 1'b1; mem_rdata = 8'h3C;
        cycle("burst_reset");
        reset = 1'b0; read_en = 1'b0;
        cycle("burst_after");

        // Random traffic, occupancy kept within DEPTH.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1 && 6'(wr_ptr - m_rd) < 6'd32)
                wr_ptr = wr_ptr + 1'b1;
            read_en = 1'($urandom_range(0, 1));
            underflow_clr = 1'($urandom_range(0, 7) == 0);
            mem_rdata = 8'($urandom);
            cycle($sformatf("rnd%0d", i));
        end
        idle_inputs();
        cycle("final");
        chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
